joy_dir_filter: RTL and testbench
=================================

JOY_DIR_FILTER -- requirements
Module: joy_dir_filter

Interface
REQ-001 The module SHALL have parameter CHANNELS, default 2, giving the number of independent joystick channels (1..8).
REQ-002 The module SHALL have parameter DEB_CYCLES, default 4, giving the debounce length in clocks; 0 means no debounce (0..255).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-005 Port dir_in, input, 4*CHANNELS bits: raw directions for channel c at [4c+3:4c] = {up,down,left,right}, asynchronous to clk.
REQ-006 Port mode, input, 2*CHANNELS bits: filter mode for channel c at [2c+1:2c]: 00 pass, 01 4-way last-pressed, 10 4-way sticky, 11 2-way horizontal.
REQ-007 Port rotate, input, 2 bits, shared by all channels: 00 none, 01 cw, 10 ccw, 11 180.
REQ-008 Port dir_out, output, 4*CHANNELS bits: filtered directions, same packing as dir_in, registered.
REQ-009 Port change, output, CHANNELS bits: one-clock pulse per channel when that channel's dir_out changes.

Function
REQ-010 Each dir_in bit SHALL pass through a 2-flop synchroniser (sync2).
REQ-011 Each bit SHALL have a stable register and a counter; stable SHALL take sync2 on the max(DEB_CYCLES,1)-th consecutive clock on which sync2 != stable; the counter SHALL clear whenever sync2 == stable.
REQ-012 Pulses on sync2 shorter than DEB_CYCLES clocks SHALL NOT reach stable.
REQ-013 Rotation SHALL be combinational on stable: cw maps up->right, right->down, down->left, left->up; ccw is the inverse; 180 swaps up<->down and left<->right. The result is called held.
REQ-014 Mode 00: next output = held.
REQ-015 Mode 01: rising edges = held & ~held_prev; on an edge, mask SHALL become the single newest direction, with priority up > down > left > right on simultaneous edges; mask SHALL return to 1111 when held & mask == 0; next output = held & next mask.
REQ-016 Mode 10: the channel SHALL hold one owned direction; while it stays held, new presses SHALL be ignored; when it is released (or none is owned), ownership SHALL pass to the highest-priority held direction (same priority as REQ-015) in the same clock; next output = owned one-hot or 0000.
REQ-017 Mode 11: up and down SHALL be forced 0; left and right held together SHALL both output 0; otherwise next output = held left/right.
REQ-018 A change of a channel's mode value SHALL reset that channel's mask to 1111 and its ownership to none on that clock, and the new mode SHALL apply from that clock.
REQ-019 dir_out SHALL register the next output, giving latency from a dir_in transition to dir_out of 2 + max(DEB_CYCLES,1) + 1 clocks.
REQ-020 change[c] SHALL be 1 exactly in the clock after dir_out[c] took a value different from its previous value.
REQ-021 Channels SHALL be fully independent; rotate changes SHALL be treated like input changes (edges may result).
REQ-022 No output SHALL ever show more than one direction in modes 01, 10 and 11, except mode 01 with mask 1111 and no edge (diagonals pass).

Reset
REQ-023 While reset is high, synchroniser, stable, counter, held_prev and dir_out SHALL be 0, mask SHALL be 1111, ownership SHALL be none, and change SHALL be 0.
REQ-024 When reset is asserted mid-debounce or mid-hold, state SHALL clear immediately, and after release the filter SHALL restart as from power-up.

Verification (CHANNELS=2, DEB_CYCLES=4)
REQ-025 Mode 00, rotate 00: ch0 up pressed -> dir_out[3:0]=1000 exactly 7 clocks later, and change[0] pulses one clock after that.
REQ-026 Mode 00: a 3-clock right glitch -> dir_out stays 0000, change stays 0; a 4-clock right pulse -> dir_out shows 0001.
REQ-027 Mode 01: hold left, then add up -> output 0010, then 1000; release up -> 0010 (mask back to 1111 then left held); up and left edges in the same clock -> 1000.
REQ-028 Mode 10: hold right, add down -> output stays 0001; release right -> 0100 in that same filter clock.
REQ-029 Mode 11 with rotate 01: raw up held -> output 0001; raw up+down (rotated to right+left) -> output 0000.
REQ-030 Assert reset with ch1 outputting 0010 -> dir_out=0, change=0 asynchronously; release with inputs idle -> outputs remain 0.

Source files
------------

// File: rtl/joy_dir_filter.sv
// joy_dir_filter: synchronise, debounce, rotate and mode-filter joystick directions per channel
//   clk     - single clock; all state changes on its rising edge
//   reset   - asynchronous active-high reset
//   dir_in  - raw {up,down,left,right} per channel at [4c+3:4c], asynchronous to clk
//   mode    - per-channel filter at [2c+1:2c]: 00 pass, 01 4-way last-pressed, 10 4-way sticky, 11 2-way horizontal
//   rotate  - shared rotation: 00 none, 01 cw, 10 ccw, 11 180
//   dir_out - registered filtered directions, same packing as dir_in
//   change  - per-channel one-clock pulse, the clock after that channel's dir_out changed
module joy_dir_filter #(
    parameter int CHANNELS   = 2,
    parameter int DEB_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*CHANNELS-1:0] dir_in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [1:0]            rotate,
    output logic [4*CHANNELS-1:0] dir_out,
    output logic [CHANNELS-1:0]   change
);
    localparam int NB = 4 * CHANNELS;
    // Counter value at which a persistent mismatch is accepted; DEB_CYCLES of 0 behaves as 1
    localparam logic [7:0] DEB_LAST = 8'((DEB_CYCLES < 1) ? 0 : DEB_CYCLES - 1);

    logic [NB-1:0] w_stable;

    // Bit layout is {up,down,left,right}
    function automatic logic [3:0] f_rotate(input logic [3:0] d, input logic [1:0] rot);
        return (rot == 2'b01) ? {d[1], d[0], d[2], d[3]} :
               (rot == 2'b10) ? {d[0], d[1], d[3], d[2]} :
               (rot == 2'b11) ? {d[2], d[3], d[0], d[1]} : d;
    endfunction

    // Highest-priority set direction as one-hot: up > down > left > right
    function automatic logic [3:0] f_first(input logic [3:0] d);
        return d[3] ? 4'b1000 : d[2] ? 4'b0100 : d[1] ? 4'b0010 : d[0] ? 4'b0001 : 4'b0000;
    endfunction

    for (genvar b = 0; b < NB; b++) begin : g_bit
        logic       r_sync1;
        logic       r_sync2;
        logic       r_stable;
        logic [7:0] r_cnt;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync1  <= 1'b0;
                r_sync2  <= 1'b0;
                r_stable <= 1'b0;
                r_cnt    <= 8'd0;
            end else begin
                r_sync1 <= dir_in[b];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_stable) begin
                    r_cnt <= 8'd0;
                end else if (r_cnt == DEB_LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= 8'd0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
        assign w_stable[b] = r_stable;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [1:0] w_mode;
        logic       w_mode_chg;
        logic [3:0] w_held;
        logic [3:0] w_edge;
        logic [3:0] w_mask_base;
        logic [3:0] w_mask_new;
        logic [3:0] w_mask_next;
        logic [3:0] w_own_base;
        logic [3:0] w_own_next;
        logic [3:0] w_next;
        logic [1:0] r_mode_prev;
        logic [3:0] r_held_prev;
        logic [3:0] r_mask;
        logic [3:0] r_own;
        logic [3:0] r_dout;
        logic [3:0] r_dout_d;
        logic       r_change;

        always_comb begin
            w_mode      = mode[2*c +: 2];
            w_mode_chg  = w_mode != r_mode_prev;
            w_held      = f_rotate(w_stable[4*c +: 4], rotate);
            w_edge      = w_held & ~r_held_prev;
            // A mode switch restarts the filter state in the same clock the new mode takes effect
            w_mask_base = w_mode_chg ? 4'b1111 : r_mask;
            w_own_base  = w_mode_chg ? 4'b0000 : r_own;
            w_mask_new  = (w_edge != 4'b0000) ? f_first(w_edge) : w_mask_base;
            // Mask falls back to all-pass once its selected direction is no longer held
            w_mask_next = (w_mode != 2'b01) ? 4'b1111 :
                          ((w_held & w_mask_new) == 4'b0000) ? 4'b1111 : w_mask_new;
            // Ownership is kept while held; otherwise handed over within the same clock
            w_own_next  = (w_mode != 2'b10) ? 4'b0000 :
                          ((w_own_base & w_held) != 4'b0000) ? w_own_base : f_first(w_held);
            w_next      = (w_mode == 2'b00) ? w_held :
                          (w_mode == 2'b01) ? (w_held & w_mask_next) :
                          (w_mode == 2'b10) ? w_own_next :
                          {2'b00, (w_held[1] & w_held[0]) ? 2'b00 : w_held[1:0]};
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_mode_prev <= 2'b00;
                r_held_prev <= 4'b0000;
                r_mask      <= 4'b1111;
                r_own       <= 4'b0000;
                r_dout      <= 4'b0000;
                r_dout_d    <= 4'b0000;
                r_change    <= 1'b0;
            end else begin
                r_mode_prev <= w_mode;
                r_held_prev <= w_held;
                r_mask      <= w_mask_next;
                r_own       <= w_own_next;
                r_dout      <= w_next;
                r_dout_d    <= r_dout;
                r_change    <= r_dout != r_dout_d;
            end
        end

        assign dir_out[4*c +: 4] = r_dout;
        assign change[c]         = r_change;
    end
endmodule

// File: tb/tb_joy_dir_filter.sv
// tb_joy_dir_filter: directed scenarios plus randomized run against a behavioural model of joy_dir_filter
module tb_joy_dir_filter;
    localparam int CH  = 2;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] dir_in = '0;
    logic [3:0] mode = '0;
    logic [1:0] rotate = '0;
    logic [7:0] dir_out;
    logic [1:0] change;

    int n_checks = 0;
    int n_fail = 0;

    joy_dir_filter #(.CHANNELS(CH), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .dir_in(dir_in), .mode(mode),
        .rotate(rotate), .dir_out(dir_out), .change(change)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- behavioural model ----------------
    logic [7:0] smp[$];
    logic [7:0] m_stable;
    logic [3:0] m_prev_held[CH];
    logic [3:0] m_dout[CH];
    logic [3:0] m_dout_old[CH];
    logic [1:0] m_mode_last[CH];
    logic       m_chg[CH];
    int         m_sel[CH];
    int         m_own[CH];

    // compass positions clockwise: 0 up, 1 right, 2 down, 3 left -> bit index
    function automatic int bit_at(input int a);
        return (a == 0) ? 3 : (a == 1) ? 0 : (a == 2) ? 2 : 1;
    endfunction

    function automatic logic [3:0] rot_model(input logic [3:0] d, input logic [1:0] r);
        int steps;
        logic [3:0] o;
        steps = (r == 2'b01) ? 1 : (r == 2'b10) ? 3 : (r == 2'b11) ? 2 : 0;
        o = '0;
        for (int a = 0; a < 4; a++) if (d[bit_at(a)]) o[bit_at((a + steps) % 4)] = 1'b1;
        return o;
    endfunction

    function automatic int first_idx(input logic [3:0] d);
        for (int i = 3; i >= 0; i--) if (d[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] o;
        o = '0;
        o[i] = 1'b1;
        return o;
    endfunction

    task automatic model_init();
        smp.delete();
        for (int i = 0; i < DEB + 2; i++) smp.push_back(8'h00);
        m_stable = '0;
        for (int c = 0; c < CH; c++) begin
            m_prev_held[c] = '0; m_dout[c] = '0; m_dout_old[c] = '0;
            m_mode_last[c] = '0; m_chg[c] = 1'b0; m_sel[c] = -1; m_own[c] = -1;
        end
    endtask

    task automatic model_step();
        logic [7:0] nstb;
        logic [3:0] h, rise, nxt;
        logic [1:0] md;
        bit all_diff;
        smp.push_back(dir_in);
        if (smp.size() > DEB + 4) void'(smp.pop_front());
        // a bit flips once the last DEB synchronised samples all disagree with it
        nstb = m_stable;
        for (int b = 0; b < 8; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) if (smp[smp.size() - 3 - j][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) nstb[b] = ~m_stable[b];
        end
        for (int c = 0; c < CH; c++) begin
            h = rot_model(m_stable[4*c +: 4], rotate);
            rise = h & ~m_prev_held[c];
            md = mode[2*c +: 2];
            if (md != m_mode_last[c]) begin m_sel[c] = -1; m_own[c] = -1; end
            nxt = '0;
            if (md == 2'b01) begin
                if (rise != 0) m_sel[c] = first_idx(rise);
                if (m_sel[c] >= 0) if (!h[m_sel[c]]) m_sel[c] = -1;
                nxt = (m_sel[c] < 0) ? h : (h & onehot(m_sel[c]));
            end else m_sel[c] = -1;
            if (md == 2'b10) begin
                if (m_own[c] < 0) m_own[c] = first_idx(h);
                else if (!h[m_own[c]]) m_own[c] = first_idx(h);
                nxt = (m_own[c] < 0) ? 4'b0000 : onehot(m_own[c]);
            end else m_own[c] = -1;
            if (md == 2'b00) nxt = h;
            if (md == 2'b11) nxt = (h[1] && h[0]) ? 4'b0000 : {2'b00, h[1:0]};
            m_mode_last[c] = md;
            m_prev_held[c] = h;
            m_chg[c] = m_dout[c] != m_dout_old[c];
            m_dout_old[c] = m_dout[c];
            m_dout[c] = nxt;
        end
        m_stable = nstb;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hold(2);
        reset = 1'b0;
        hold(2);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        hold(2);
        n_checks++;
        if (dir_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%b exp=%b", dir_out, 8'h00); end
        n_checks++;
        if (change !== 2'b00) begin n_fail++; $display("FAIL reset_change got=%b exp=%b", change, 2'b00); end
    endtask

    task automatic test_latency();
        logic [3:0] exp_d;
        mode = 4'b0000; rotate = 2'b00; dir_in = 8'h00;
        do_reset();
        dir_in = 8'h08;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            exp_d = (j >= 7) ? 4'b1000 : 4'b0000;
            n_checks++;
            if (dir_out[3:0] !== exp_d) begin n_fail++; $display("FAIL latency_dout clk=%0d got=%b exp=%b", j, dir_out[3:0], exp_d); end
            n_checks++;
            if (change[0] !== (j == 8)) begin n_fail++; $display("FAIL latency_change clk=%0d got=%b exp=%b", j, change[0], j == 8); end
        end
        n_checks++;
        if (dir_out[7:4] !== 4'b0000) begin n_fail++; $display("FAIL latency_ch1_idle got=%b exp=0000", dir_out[7:4]); end
    endtask

    task automatic test_glitch();
        logic [3:0] exp_d;
        mode = 4'b0000; rotate = 2'b00; dir_in = 8'h00;
        do_reset();
        dir_in = 8'h01;
        hold(3);
        dir_in = 8'h00;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            n_checks++;
            if (dir_out !== 8'h00 || change !== 2'b00) begin
                n_fail++; $display("FAIL glitch3 clk=%0d dout=%b chg=%b exp=0/0", j, dir_out, change);
            end
        end
        dir_in = 8'h01;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            exp_d = (j >= 7 && j <= 10) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (dir_out[3:0] !== exp_d) begin n_fail++; $display("FAIL pulse4_dout clk=%0d got=%b exp=%b", j, dir_out[3:0], exp_d); end
            n_checks++;
            if (change[0] !== (j == 8 || j == 12)) begin n_fail++; $display("FAIL pulse4_change clk=%0d got=%b", j, change[0]); end
            if (j == 4) dir_in = 8'h00;
        end
    endtask

    task automatic test_mode01();
        logic [7:0] steps_in[5];
        logic [3:0] steps_exp[5];
        steps_in  = '{8'h02, 8'h0A, 8'h02, 8'h00, 8'h0A};
        steps_exp = '{4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b1000};
        mode = 4'b0001; rotate = 2'b00; dir_in = 8'h00;
        do_reset();
        for (int s = 0; s < 5; s++) begin
            dir_in = steps_in[s];
            hold(10);
            n_checks++;
            if (dir_out[3:0] !== steps_exp[s]) begin n_fail++; $display("FAIL mode01 step=%0d got=%b exp=%b", s, dir_out[3:0], steps_exp[s]); end
        end
    endtask

    task automatic test_mode10();
        mode = 4'b0010; rotate = 2'b00; dir_in = 8'h00;
        do_reset();
        dir_in = 8'h01;
        hold(10);
        n_checks++;
        if (dir_out[3:0] !== 4'b0001) begin n_fail++; $display("FAIL mode10_right got=%b exp=0001", dir_out[3:0]); end
        dir_in = 8'h05;
        hold(10);
        n_checks++;
        if (dir_out[3:0] !== 4'b0001) begin n_fail++; $display("FAIL mode10_keep got=%b exp=0001", dir_out[3:0]); end
        dir_in = 8'h04;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            n_checks++;
            if (dir_out[3:0] !== 4'b0001 && dir_out[3:0] !== 4'b0100) begin
                n_fail++; $display("FAIL mode10_handover clk=%0d got=%b exp=0001|0100", j, dir_out[3:0]);
            end
        end
        n_checks++;
        if (dir_out[3:0] !== 4'b0100) begin n_fail++; $display("FAIL mode10_down got=%b exp=0100", dir_out[3:0]); end
    endtask

    task automatic test_mode11();
        mode = 4'b0011; rotate = 2'b01; dir_in = 8'h00;
        do_reset();
        dir_in = 8'h08;
        hold(10);
        n_checks++;
        if (dir_out[3:0] !== 4'b0001) begin n_fail++; $display("FAIL mode11_cw_up got=%b exp=0001", dir_out[3:0]); end
        dir_in = 8'h0C;
        hold(10);
        n_checks++;
        if (dir_out[3:0] !== 4'b0000) begin n_fail++; $display("FAIL mode11_both got=%b exp=0000", dir_out[3:0]); end
        rotate = 2'b00;
        dir_in = 8'h08;
        hold(10);
        n_checks++;
        if (dir_out[3:0] !== 4'b0000) begin n_fail++; $display("FAIL mode11_up_blocked got=%b exp=0000", dir_out[3:0]); end
    endtask

    task automatic test_async_reset();
        mode = 4'b0100; rotate = 2'b00; dir_in = 8'h00;
        do_reset();
        dir_in = 8'h20;
        hold(10);
        n_checks++;
        if (dir_out !== 8'h20) begin n_fail++; $display("FAIL areset_pre got=%b exp=%b", dir_out, 8'h20); end
        dir_in = 8'h21;
        hold(3);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dir_out !== 8'h00 || change !== 2'b00) begin
            n_fail++; $display("FAIL areset_immediate dout=%b chg=%b exp=0/0", dir_out, change);
        end
        @(negedge clk);
        dir_in = 8'h00;
        hold(2);
        reset = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            n_checks++;
            if (dir_out !== 8'h00 || change !== 2'b00) begin
                n_fail++; $display("FAIL areset_after clk=%0d dout=%b chg=%b exp=0/0", j, dir_out, change);
            end
        end
    endtask

    task automatic test_random();
        int rst_left;
        int k;
        rst_left = 2;
        reset = 1'b1; dir_in = 8'h00; mode = 4'($urandom); rotate = 2'b00;
        model_init();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            if (reset) model_init(); else model_step();
            @(negedge clk);
            n_checks++;
            if (dir_out !== {m_dout[1], m_dout[0]}) begin
                n_fail++; $display("FAIL random_dout cyc=%0d got=%b exp=%b", cyc, dir_out, {m_dout[1], m_dout[0]});
            end
            n_checks++;
            if (change !== {m_chg[1], m_chg[0]}) begin
                n_fail++; $display("FAIL random_change cyc=%0d got=%b exp=%b", cyc, change, {m_chg[1], m_chg[0]});
            end
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset = 1'b0;
            end else if ($urandom_range(499) == 0) begin
                reset = 1'b1;
                model_init();
                rst_left = $urandom_range(3, 1);
            end
            if ($urandom_range(5) == 0) begin
                k = $urandom_range(7);
                dir_in[k] = ~dir_in[k];
            end
            if ($urandom_range(149) == 0) begin
                k = $urandom_range(1);
                mode[2*k +: 2] = 2'($urandom_range(3));
            end
            if ($urandom_range(299) == 0) rotate = 2'($urandom_range(3));
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_mode01();
        test_mode10();
        test_mode11();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
